// File: rtl/id_ex_operand_stage.sv
// rtl/id_ex_operand_stage.sv - ID/EX pipeline register with load-use bubble, forwarding and ALU operand select
// Optional macro: EX_FORWARD_EN enables EX/MEM and MEM/WB result forwarding onto the operand paths.
module id_ex_operand_stage #(
    parameter int DATA_W = 32,
    parameter int RA_W   = 5,
    parameter int CTRL_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [15:0]       id_imm,
    input  logic [4:0]        id_shamt,
    input  logic [RA_W-1:0]   id_rs,
    input  logic [RA_W-1:0]   id_rt,
    input  logic [RA_W-1:0]   id_dest,
    input  logic [CTRL_W-1:0] id_alu_control,
    input  logic              id_alu_src,
    input  logic              id_imm_zext,
    input  logic              id_shift_sel,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              exm_reg_write,
    input  logic [RA_W-1:0]   exm_dest,
    input  logic [DATA_W-1:0] exm_result,
    input  logic              mwb_reg_write,
    input  logic [RA_W-1:0]   mwb_dest,
    input  logic [DATA_W-1:0] mwb_data,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [CTRL_W-1:0] alu_control,
    output logic [DATA_W-1:0] ex_store_data,
    output logic              ex_valid,
    output logic [RA_W-1:0]   ex_dest,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              hazard_stall
);

    logic              valid_q;
    logic              reg_write_q;
    logic              mem_read_q;
    logic [CTRL_W-1:0] alu_control_q;
    logic [RA_W-1:0]   dest_q;
    logic [RA_W-1:0]   rs_q;
    logic [RA_W-1:0]   rt_q;
    logic [DATA_W-1:0] rs_data_q;
    logic [DATA_W-1:0] rt_data_q;
    logic [15:0]       imm_q;
    logic [4:0]        shamt_q;
    logic              alu_src_q;
    logic              imm_zext_q;
    logic              shift_sel_q;

    logic [DATA_W-1:0] fwd_rs;
    logic [DATA_W-1:0] fwd_rt;
    logic [DATA_W-1:0] ext_imm;
    logic              bubble;

    assign ex_valid     = valid_q;
    assign ex_dest      = dest_q;
    assign alu_control  = alu_control_q;
    assign ex_reg_write = valid_q & reg_write_q;
    assign ex_mem_read  = valid_q & mem_read_q;

    // Load-use: the load in EX cannot supply its data until MEM/WB.
    assign hazard_stall = id_valid & ex_mem_read & (ex_dest != '0) &
                          ((ex_dest == id_rs) | (ex_dest == id_rt));

    // Flush beats stall; a load-use bubble only applies when the stage is free to advance.
    assign bubble = flush | (~stall & hazard_stall);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q       <= 1'b0;
            reg_write_q   <= 1'b0;
            mem_read_q    <= 1'b0;
            alu_control_q <= '0;
            dest_q        <= '0;
            rs_q          <= '0;
            rt_q          <= '0;
            rs_data_q     <= '0;
            rt_data_q     <= '0;
            imm_q         <= '0;
            shamt_q       <= '0;
            alu_src_q     <= 1'b0;
            imm_zext_q    <= 1'b0;
            shift_sel_q   <= 1'b0;
        end else if (bubble) begin
            valid_q       <= 1'b0;
            reg_write_q   <= 1'b0;
            mem_read_q    <= 1'b0;
            alu_control_q <= '0;
        end else if (!stall) begin
            valid_q       <= id_valid;
            reg_write_q   <= id_reg_write;
            mem_read_q    <= id_mem_read;
            alu_control_q <= id_alu_control;
            dest_q        <= id_dest;
            rs_q          <= id_rs;
            rt_q          <= id_rt;
            rs_data_q     <= id_rs_data;
            rt_data_q     <= id_rt_data;
            imm_q         <= id_imm;
            shamt_q       <= id_shamt;
            alu_src_q     <= id_alu_src;
            imm_zext_q    <= id_imm_zext;
            shift_sel_q   <= id_shift_sel;
        end
    end

`ifdef EX_FORWARD_EN
    // The younger producer (EX/MEM) takes precedence; register 0 is hardwired and never forwarded.
    always_comb begin
        fwd_rs = rs_data_q;
        if (exm_reg_write && (exm_dest != '0) && (exm_dest == rs_q)) begin
            fwd_rs = exm_result;
        end else if (mwb_reg_write && (mwb_dest != '0) && (mwb_dest == rs_q)) begin
            fwd_rs = mwb_data;
        end
    end

    always_comb begin
        fwd_rt = rt_data_q;
        if (exm_reg_write && (exm_dest != '0) && (exm_dest == rt_q)) begin
            fwd_rt = exm_result;
        end else if (mwb_reg_write && (mwb_dest != '0) && (mwb_dest == rt_q)) begin
            fwd_rt = mwb_data;
        end
    end
`else
    // Software schedules NOPs around dependencies, so the bypass buses are not consulted.
    logic unused_fwd;
    assign unused_fwd = ^{exm_reg_write, exm_dest, exm_result,
                          mwb_reg_write, mwb_dest, mwb_data, rs_q, rt_q};
    assign fwd_rs = rs_data_q;
    assign fwd_rt = rt_data_q;
`endif

    assign ext_imm       = imm_zext_q ? {{(DATA_W-16){1'b0}}, imm_q}
                                      : {{(DATA_W-16){imm_q[15]}}, imm_q};
    assign alu_a         = shift_sel_q ? {{(DATA_W-5){1'b0}}, shamt_q} : fwd_rs;
    assign alu_b         = alu_src_q ? ext_imm : fwd_rt;
    assign ex_store_data = fwd_rt;

endmodule
